// File: rtl/logger_pkg.sv
// Shared types and helper constants for the multi-channel sample logger.
package logger_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FULL    = 2'd2
  } state_e;

  function automatic int depth_of(input int nb_addr);
    return 32'd1 << nb_addr;
  endfunction

  // Channel-select width never drops below one bit, even for a single channel.
  function automatic int ch_sel_w(input int nb_ch);
    return (nb_ch > 1) ? $clog2(nb_ch) : 32'd1;
  endfunction

endpackage

// File: rtl/logger_ram.sv
// Simple dual-port log storage: one write port, one registered read port (BRAM style, no reset).
module logger_ram #(
  parameter int WIDTH = 32,
  parameter int AW    = 15
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] mem [2**AW];
  logic [WIDTH-1:0] rdata_q;

  // Write port
  always_ff @(posedge clk) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read port
  always_ff @(posedge clk) begin
    if (i_re) begin
      rdata_q <= mem[i_raddr];
    end
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/multi_ch_logger.sv
// Multi-channel capture logger: IDLE/CAPTURE/FULL control, log RAM, 2-cycle read pipeline.
// Optional sample decimation is enabled by defining LOGGER_DECIM_EN.
module multi_ch_logger
  import logger_pkg::*;
#(
  parameter int NB_DATA  = 16,
  parameter int NB_ADDR  = 15,
  parameter int NB_CH    = 2,
  parameter int NB_DECIM = 8
) (
  input  logic                         clk,
  input  logic                         i_rst,
  input  logic [NB_CH*NB_DATA-1:0]     i_data,
  input  logic                         i_valid,
  input  logic                         i_run_log,
  input  logic                         i_read_log,
  input  logic [NB_ADDR-1:0]           i_addr,
  input  logic [ch_sel_w(NB_CH)-1:0]   i_ch_sel,
  input  logic [NB_DECIM-1:0]          i_decim,
  output logic [2*NB_DATA-1:0]         o_data,
  output logic                         o_data_valid,
  output logic                         o_mem_full,
  output logic                         o_busy,
  output logic [NB_ADDR:0]             o_wr_count
);

  localparam int CSW   = ch_sel_w(NB_CH);
  localparam int CW    = NB_ADDR + 1;
  localparam int DEPTH = depth_of(NB_ADDR);
  localparam logic [NB_ADDR:0] LAST_IDX = CW'(DEPTH - 1);

  state_e                   state_q, state_d;
  logic [NB_ADDR:0]         wr_count_q, wr_count_d;
  logic                     mem_full_q, mem_full_d;
  logic                     busy_q, busy_d;
  logic                     run_q;
  logic                     run_edge_s;
  logic                     accept_s;
  logic                     wr_en_s;
  logic                     rd_en_s;
  logic                     rd_vld1_q;
  logic [CSW-1:0]           ch1_q;
  logic [NB_CH*NB_DATA-1:0] ram_rdata_s;
  logic [NB_DATA-1:0]       lane_s;
  logic [2*NB_DATA-1:0]     data_q, data_d;
  logic                     data_valid_q;

`ifdef LOGGER_DECIM_EN
  logic [NB_DECIM-1:0]      dcnt_q, dcnt_d;
`else
  logic                     decim_unused_s;
  assign decim_unused_s = ^i_decim;
`endif

  assign run_edge_s = i_run_log & ~run_q;
  assign rd_en_s    = i_read_log & ((state_q == ST_IDLE) | (state_q == ST_FULL));

  // Next-state, write-enable and counter logic; a restart edge overrides everything else.
  always_comb begin
    state_d    = state_q;
    wr_count_d = wr_count_q;
    mem_full_d = mem_full_q;
    wr_en_s    = 1'b0;
`ifdef LOGGER_DECIM_EN
    dcnt_d     = dcnt_q;
    accept_s   = (dcnt_q == {NB_DECIM{1'b0}});
`else
    accept_s   = 1'b1;
`endif
    if (run_edge_s) begin
      state_d    = ST_CAPTURE;
      wr_count_d = {CW{1'b0}};
      mem_full_d = 1'b0;
`ifdef LOGGER_DECIM_EN
      dcnt_d     = {NB_DECIM{1'b0}};
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_FULL: begin
          state_d = state_q;
        end
        ST_CAPTURE: begin
          if (i_valid) begin
`ifdef LOGGER_DECIM_EN
            dcnt_d = (dcnt_q == i_decim) ? {NB_DECIM{1'b0}} : dcnt_q + {{(NB_DECIM-1){1'b0}}, 1'b1};
`endif
            if (accept_s) begin
              wr_en_s    = 1'b1;
              wr_count_d = wr_count_q + {{NB_ADDR{1'b0}}, 1'b1};
              if (wr_count_q == LAST_IDX) begin
                state_d    = ST_FULL;
                mem_full_d = 1'b1;
              end else begin
                state_d    = ST_CAPTURE;
              end
            end else begin
              wr_en_s = 1'b0;
            end
          end else begin
            wr_en_s = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    busy_d = (state_d == ST_CAPTURE);
  end

  // Lane select for the read pipeline; out-of-range selects read as zero.
  always_comb begin
    lane_s = {NB_DATA{1'b0}};
    for (int k = 0; k < NB_CH; k++) begin
      lane_s = (ch1_q == CSW'(k)) ? ram_rdata_s[k*NB_DATA +: NB_DATA] : lane_s;
    end
    data_d = rd_vld1_q ? {{NB_DATA{1'b0}}, lane_s} : data_q;
  end

  // Control and read-pipeline registers
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      wr_count_q   <= {CW{1'b0}};
      mem_full_q   <= 1'b0;
      busy_q       <= 1'b0;
      run_q        <= 1'b0;
      rd_vld1_q    <= 1'b0;
      ch1_q        <= {CSW{1'b0}};
      data_q       <= {(2*NB_DATA){1'b0}};
      data_valid_q <= 1'b0;
`ifdef LOGGER_DECIM_EN
      dcnt_q       <= {NB_DECIM{1'b0}};
`endif
    end else begin
      state_q      <= state_d;
      wr_count_q   <= wr_count_d;
      mem_full_q   <= mem_full_d;
      busy_q       <= busy_d;
      run_q        <= i_run_log;
      rd_vld1_q    <= rd_en_s;
      ch1_q        <= i_ch_sel;
      data_q       <= data_d;
      data_valid_q <= rd_vld1_q;
`ifdef LOGGER_DECIM_EN
      dcnt_q       <= dcnt_d;
`endif
    end
  end

  logger_ram #(
    .WIDTH (NB_CH*NB_DATA),
    .AW    (NB_ADDR)
  ) u_ram (
    .clk     (clk),
    .i_we    (wr_en_s),
    .i_waddr (wr_count_q[NB_ADDR-1:0]),
    .i_wdata (i_data),
    .i_re    (rd_en_s),
    .i_raddr (i_addr),
    .o_rdata (ram_rdata_s)
  );

  assign o_data       = data_q;
  assign o_data_valid = data_valid_q;
  assign o_mem_full   = mem_full_q;
  assign o_busy       = busy_q;
  assign o_wr_count   = wr_count_q;

endmodule

// File: tb/tb_multi_ch_logger.sv
// Directed self-checking bench for multi_ch_logger (NB_ADDR=4, two 16-bit channels).
module tb_multi_ch_logger;

  logic        clk;
  logic        i_rst;
  logic [31:0] i_data;
  logic        i_valid;
  logic        i_run_log;
  logic        i_read_log;
  logic [3:0]  i_addr;
  logic [0:0]  i_ch_sel;
  logic [7:0]  i_decim;
  logic [31:0] o_data;
  logic        o_data_valid;
  logic        o_mem_full;
  logic        o_busy;
  logic [4:0]  o_wr_count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  multi_ch_logger #(
    .NB_DATA (16),
    .NB_ADDR (4),
    .NB_CH   (2),
    .NB_DECIM(8)
  ) dut (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .i_run_log   (i_run_log),
    .i_read_log  (i_read_log),
    .i_addr      (i_addr),
    .i_ch_sel    (i_ch_sel),
    .i_decim     (i_decim),
    .o_data      (o_data),
    .o_data_valid(o_data_valid),
    .o_mem_full  (o_mem_full),
    .o_busy      (o_busy),
    .o_wr_count  (o_wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic run_pulse();
    i_run_log = 1'b1;
    tick();
    i_run_log = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a, input logic c,
                         output logic [31:0] d, output logic v1, output logic v2);
    i_read_log = 1'b1;
    i_addr     = a;
    i_ch_sel   = c;
    tick();
    i_read_log = 1'b0;
    v1 = o_data_valid;
    tick();
    d  = o_data;
    v2 = o_data_valid;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
    tick();
    total_cnt++; if (o_busy !== 1'b0) $display("FAIL rst_busy got %0h exp 0", o_busy); else pass_cnt++;
    total_cnt++; if (o_mem_full !== 1'b0) $display("FAIL rst_full got %0h exp 0", o_mem_full); else pass_cnt++;
    total_cnt++; if (o_wr_count !== 5'd0) $display("FAIL rst_count got %0d exp 0", o_wr_count); else pass_cnt++;
    total_cnt++; if (o_data_valid !== 1'b0) $display("FAIL rst_dvalid got %0h exp 0", o_data_valid); else pass_cnt++;
    total_cnt++; if (o_data !== 32'h0) $display("FAIL rst_data got %08h exp 0", o_data); else pass_cnt++;
  endtask

  task automatic test_fill();
    logic [31:0] d;
    logic v1, v2;
    run_pulse();
    total_cnt++; if (o_busy !== 1'b1) $display("FAIL fill_busy got %0h exp 1", o_busy); else pass_cnt++;
    for (int n = 0; n < 16; n++) begin
      i_valid = 1'b1;
      i_data  = {16'h1000 + 16'(n), 16'(n)};
      tick();
      total_cnt++; if (o_wr_count !== 5'(n + 1)) $display("FAIL fill_count n=%0d got %0d exp %0d", n, o_wr_count, n + 1); else pass_cnt++;
      total_cnt++; if (o_mem_full !== (n == 15)) $display("FAIL fill_full n=%0d got %0h exp %0h", n, o_mem_full, (n == 15)); else pass_cnt++;
    end
    i_valid = 1'b0;
    total_cnt++; if (o_busy !== 1'b0) $display("FAIL fill_busy_end got %0h exp 0", o_busy); else pass_cnt++;
    do_read(4'd5, 1'b1, d, v1, v2);
    total_cnt++; if (v1 !== 1'b0) $display("FAIL fill_rd_early got %0h exp 0", v1); else pass_cnt++;
    total_cnt++; if (v2 !== 1'b1) $display("FAIL fill_rd_valid got %0h exp 1", v2); else pass_cnt++;
    total_cnt++; if (d !== 32'h00001005) $display("FAIL fill_rd_data got %08h exp 00001005", d); else pass_cnt++;
    tick();
    total_cnt++; if (o_data_valid !== 1'b0) $display("FAIL fill_rd_pulse got %0h exp 0", o_data_valid); else pass_cnt++;
    do_read(4'd15, 1'b0, d, v1, v2);
    total_cnt++; if (d !== 32'h0000000F) $display("FAIL fill_rd_last got %08h exp 0000000f", d); else pass_cnt++;
  endtask

  task automatic test_full_ignore();
    logic [31:0] d;
    logic v1, v2;
    for (int n = 0; n < 5; n++) begin
      i_valid = 1'b1;
      i_data  = 32'hDEAD_BEEF;
      tick();
    end
    i_valid = 1'b0;
    total_cnt++; if (o_wr_count !== 5'd16) $display("FAIL full_count got %0d exp 16", o_wr_count); else pass_cnt++;
    total_cnt++; if (o_mem_full !== 1'b1) $display("FAIL full_flag got %0h exp 1", o_mem_full); else pass_cnt++;
    do_read(4'd0, 1'b0, d, v1, v2);
    total_cnt++; if (d !== 32'h00000000 || v2 !== 1'b1) $display("FAIL full_rd0 got %08h/%0h exp 00000000/1", d, v2); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 6; c++) begin
      i_read_log = (c < 4);
      i_addr     = 4'(c);
      i_ch_sel   = 1'b1;
      tick();
      total_cnt++;
      if (o_data_valid !== ((c >= 1) && (c <= 4)))
        $display("FAIL b2b_valid c=%0d got %0h exp %0h", c, o_data_valid, ((c >= 1) && (c <= 4)));
      else pass_cnt++;
      if (c >= 1 && c <= 4) begin
        total_cnt++;
        if (o_data !== 32'h00001000 + 32'(c - 1)) $display("FAIL b2b_data c=%0d got %08h exp %08h", c, o_data, 32'h00001000 + 32'(c - 1));
        else pass_cnt++;
      end
    end
    i_read_log = 1'b0;
  endtask

  task automatic test_read_in_capture();
    run_pulse();
    i_read_log = 1'b1;
    i_addr     = 4'd0;
    i_ch_sel   = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      total_cnt++; if (o_data_valid !== 1'b0) $display("FAIL cap_rd_valid c=%0d got %0h exp 0", c, o_data_valid); else pass_cnt++;
    end
    i_read_log = 1'b0;
    total_cnt++; if (o_data !== 32'h00001003) $display("FAIL cap_rd_hold got %08h exp 00001003", o_data); else pass_cnt++;
  endtask

  task automatic test_restart();
    logic [31:0] d;
    logic v1, v2;
    for (int n = 0; n < 7; n++) begin
      i_valid = 1'b1;
      i_data  = {16'hA000 + 16'(n), 16'hB000 + 16'(n)};
      tick();
    end
    total_cnt++; if (o_wr_count !== 5'd7) $display("FAIL rs_pre_count got %0d exp 7", o_wr_count); else pass_cnt++;
    i_run_log = 1'b1;
    i_data    = 32'hCCCC_DDDD;
    tick();
    i_run_log = 1'b0;
    total_cnt++; if (o_busy !== 1'b1) $display("FAIL rs_busy got %0h exp 1", o_busy); else pass_cnt++;
    total_cnt++; if (o_wr_count !== 5'd0) $display("FAIL rs_count got %0d exp 0", o_wr_count); else pass_cnt++;
    i_data = {16'h2222, 16'h3333};
    tick();
    total_cnt++; if (o_wr_count !== 5'd1) $display("FAIL rs_count1 got %0d exp 1", o_wr_count); else pass_cnt++;
    for (int n = 1; n < 16; n++) begin
      i_data = {16'h5000 + 16'(n), 16'h6000 + 16'(n)};
      tick();
    end
    i_valid = 1'b0;
    total_cnt++; if (o_mem_full !== 1'b1) $display("FAIL rs_full got %0h exp 1", o_mem_full); else pass_cnt++;
    do_read(4'd0, 1'b0, d, v1, v2);
    total_cnt++; if (d !== 32'h00003333) $display("FAIL rs_rd0 got %08h exp 00003333", d); else pass_cnt++;
    do_read(4'd7, 1'b1, d, v1, v2);
    total_cnt++; if (d !== 32'h00005007) $display("FAIL rs_rd7 got %08h exp 00005007", d); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic v1, v2;
    run_pulse();
    for (int n = 0; n < 3; n++) begin
      i_valid = 1'b1;
      i_data  = {16'h7777, 16'h8888};
      tick();
    end
    i_valid = 1'b0;
    total_cnt++; if (o_wr_count !== 5'd3) $display("FAIL mid_pre_count got %0d exp 3", o_wr_count); else pass_cnt++;
    i_rst = 1'b1;
    #1;
    total_cnt++; if (o_busy !== 1'b0 || o_wr_count !== 5'd0) $display("FAIL mid_async got busy %0h count %0d exp 0/0", o_busy, o_wr_count); else pass_cnt++;
    tick();
    i_rst = 1'b0;
    tick();
    total_cnt++; if (o_busy !== 1'b0) $display("FAIL mid_busy got %0h exp 0", o_busy); else pass_cnt++;
    total_cnt++; if (o_mem_full !== 1'b0) $display("FAIL mid_full got %0h exp 0", o_mem_full); else pass_cnt++;
    total_cnt++; if (o_data !== 32'h0 || o_data_valid !== 1'b0) $display("FAIL mid_data got %08h/%0h exp 0/0", o_data, o_data_valid); else pass_cnt++;
    for (int n = 0; n < 3; n++) begin
      i_valid = 1'b1;
      i_data  = 32'h1234_5678;
      tick();
    end
    i_valid = 1'b0;
    total_cnt++; if (o_wr_count !== 5'd0) $display("FAIL mid_norun_count got %0d exp 0", o_wr_count); else pass_cnt++;
    do_read(4'd10, 1'b1, d, v1, v2);
    total_cnt++; if (d !== 32'h0000500A || v2 !== 1'b1) $display("FAIL mid_rd10 got %08h/%0h exp 0000500a/1", d, v2); else pass_cnt++;
    do_read(4'd3, 1'b0, d, v1, v2);
    total_cnt++; if (d !== 32'h00006003) $display("FAIL mid_rd3 got %08h exp 00006003", d); else pass_cnt++;
  endtask

`ifdef LOGGER_DECIM_EN
  task automatic test_decim();
    logic [31:0] d;
    logic v1, v2;
    i_decim = 8'd2;
    run_pulse();
    for (int n = 0; n < 48; n++) begin
      i_valid = 1'b1;
      i_data  = {16'h1000 + 16'(n), 16'(n)};
      tick();
      if (n == 44) begin
        total_cnt++; if (o_mem_full !== 1'b0) $display("FAIL dec_full44 got %0h exp 0", o_mem_full); else pass_cnt++;
      end
      if (n == 45) begin
        total_cnt++; if (o_mem_full !== 1'b1) $display("FAIL dec_full45 got %0h exp 1", o_mem_full); else pass_cnt++;
      end
    end
    i_valid = 1'b0;
    do_read(4'd1, 1'b0, d, v1, v2);
    total_cnt++; if (d !== 32'h00000003) $display("FAIL dec_rd1 got %08h exp 00000003", d); else pass_cnt++;
    do_read(4'd15, 1'b1, d, v1, v2);
    total_cnt++; if (d !== 32'h0000102D) $display("FAIL dec_rd15 got %08h exp 0000102d", d); else pass_cnt++;
  endtask
`endif

  initial begin
    i_rst      = 1'b1;
    i_data     = 32'h0;
    i_valid    = 1'b0;
    i_run_log  = 1'b0;
    i_read_log = 1'b0;
    i_addr     = 4'd0;
    i_ch_sel   = 1'b0;
    i_decim    = 8'd0;
    test_reset();
    test_fill();
    test_full_ignore();
    test_back_to_back();
    test_read_in_capture();
    test_restart();
    test_reset_mid();
`ifdef LOGGER_DECIM_EN
    test_decim();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/multi_ch_logger.md
MULTI_CH_LOGGER -- requirements
Module: multi_ch_logger

Interface
REQ-001 SHALL have parameter NB_DATA, default 16, meaning the sample width per channel in bits.
REQ-002 SHALL have parameter NB_ADDR, default 15, meaning the log depth exponent: DEPTH = 2**NB_ADDR entries.
REQ-003 SHALL have parameter NB_CH, default 2, meaning the number of channels captured per entry.
REQ-004 SHALL have parameter NB_DECIM, default 8, meaning the width of the decimation setting.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port i_rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port i_data, input, NB_CH*NB_DATA bits: channel k occupies bits [k*NB_DATA +: NB_DATA].
REQ-008 SHALL have port i_valid, input, 1 bit: i_data qualifier.
REQ-009 SHALL have port i_run_log, input, 1 bit: a rising edge starts or restarts a capture.
REQ-010 SHALL have port i_read_log, input, 1 bit: read enable.
REQ-011 SHALL have port i_addr, input, NB_ADDR bits: read address.
REQ-012 SHALL have port i_ch_sel, input, $clog2(NB_CH) bits (minimum 1): read channel select.
REQ-013 SHALL have port i_decim, input, NB_DECIM bits: decimation setting.
REQ-014 SHALL have port o_data, output, 2*NB_DATA bits: read data, laid out as {zero-pad, selected channel}.
REQ-015 SHALL have port o_data_valid, output, 1 bit: read-data strobe.
REQ-016 SHALL have port o_mem_full, output, 1 bit: log is complete.
REQ-017 SHALL have port o_busy, output, 1 bit: capture in progress.
REQ-018 SHALL have port o_wr_count, output, NB_ADDR+1 bits: number of entries written.

Function
REQ-019 SHALL implement FSM states IDLE, CAPTURE and FULL.
REQ-020 SHALL treat a registered rising edge of i_run_log, in any state, as a start/restart: next state CAPTURE, write pointer 0, o_wr_count 0, o_mem_full 0.
REQ-021 SHALL, in CAPTURE, write all NB_CH lanes of i_data to entry wr_ptr in one cycle on each accepted sample, then increment wr_ptr and o_wr_count.
REQ-022 SHALL write nothing when i_valid=0.
REQ-023 SHALL, on the write of entry DEPTH-1, move to FULL on the next cycle with o_mem_full=1 and o_wr_count=DEPTH; the pointer SHALL NOT wrap, and samples are ignored in FULL.
REQ-024 SHALL give a restart edge priority when it coincides with the final write: the result is CAPTURE, count 0.
REQ-025 SHALL assert o_busy exactly while in CAPTURE.
REQ-026 SHALL, in IDLE or FULL with i_read_log=1, present lane i_ch_sel of entry i_addr on o_data 2 cycles later, with o_data_valid pulsing alongside it; reads are pipelined at one per cycle.
REQ-027 SHALL ignore reads in CAPTURE: o_data holds and o_data_valid stays 0.
REQ-028 SHALL drive o_data to zero for an i_ch_sel value >= NB_CH.

Reset
REQ-029 SHALL, on i_rst, immediately set state IDLE, wr_ptr 0, o_wr_count 0, o_mem_full 0, o_busy 0, o_data 0, o_data_valid 0, the decimation counter 0 and the run-edge register 0.
REQ-030 SHALL leave log memory contents uncleared by reset.
REQ-031 SHALL, on a reset mid-capture, abandon the capture; a new i_run_log rising edge is required after reset release.

Configuration
REQ-032 SHALL, with LOGGER_DECIM_EN defined, accept a sample only on every (i_decim+1)-th valid sample: the decimation counter counts i_valid cycles, the first valid after a start is accepted, and the counter clears on start.
REQ-033 SHALL, with LOGGER_DECIM_EN undefined, accept every valid sample; i_decim stays present but is ignored and no counter is synthesised.

Structure
REQ-034 SHALL take the FSM state type and encodings, and the DEPTH/channel-select-width helper constants, from shared package logger_pkg.
REQ-035 SHALL place the memory in sub-module logger_ram: simple dual-port, NB_CH*NB_DATA wide, one write port, one registered read port, inferable as BRAM.

Verification (NB_DATA=16, NB_ADDR=4, NB_CH=2, NB_DECIM=8)
REQ-036 SHALL cover: run edge, then 16 valid samples {ch1=0x1000+n, ch0=n} -> o_mem_full=1 one cycle after the 16th write; o_wr_count=16; a read of addr 5 ch1 returns 0x00001005 two cycles later.
REQ-037 SHALL cover: valid samples while FULL -> o_wr_count stays 16 and a read of addr 0 ch0 still returns 0x00000000.
REQ-038 SHALL cover: run edge after 7 writes -> o_busy stays 1, o_wr_count=0, and the next sample lands at addr 0.
REQ-039 SHALL cover: i_rst pulsed after 3 writes -> all outputs 0 and state IDLE; a prior FULL log is still readable with its old data.
REQ-040 SHALL cover: LOGGER_DECIM_EN defined, i_decim=2, 48 consecutive valids n=0..47 -> stored samples n=0,3,...,45 and FULL after the 46th valid.
REQ-041 SHALL cover: i_read_log asserted in CAPTURE -> o_data_valid stays 0; back-to-back reads of addrs 0..3 in FULL -> 4 consecutive valid outputs in address order.
